manchester_sync_ctrl: RTL



---
 rtl/manchester_sync_pkg.sv | 21 ++
 rtl/manchester_sync_product.sv | 18 +
 rtl/manchester_sync_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/manchester_sync_pkg.sv
// Shared definitions for the Manchester preamble correlator.
//   SYM_POS / SYM_NEG : 2-bit signed soft-symbol codes for +1 / -1
//   state_e           : correlator controller FSM states
//   pre_bit_to_sym    : maps a reference preamble bit to its symbol code
package manchester_sync_pkg;

    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CMP  = 2'd2
    } state_e;

    // Reference bit 1 means +1, bit 0 means -1.
    function automatic logic [1:0] pre_bit_to_sym(input logic b);
        return b ? SYM_POS : SYM_NEG;
    endfunction

endpackage

// File: rtl/manchester_sync_product.sv
// Generic signed product unit.
//   i_a : signed operand, A_W bits
//   i_b : signed operand, B_W bits
//   o_p : signed product truncated to P_W bits
// For +/-1 operands at width 2 the truncated product is exactly +/-1.
module product #(
    parameter int A_W = 2,
    parameter int B_W = 2,
    parameter int P_W = 2
) (
    input  logic signed [A_W-1:0] i_a,
    input  logic signed [B_W-1:0] i_b,
    output logic signed [P_W-1:0] o_p
);

    assign o_p = P_W'(i_a * i_b);

endmodule

// File: rtl/manchester_sync_ctrl.sv
// Preamble correlator controller for the Manchester receive path.
// Keeps the last TAP_NUM soft symbols and, after each accepted symbol,
// correlates them against PREAMBLE one tap per cycle through a single
// shared product unit. A one-cycle sync pulse and a sticky lock flag are
// raised when the correlation reaches THRESH with a full history.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_enable                 : permits new symbol acceptance
//   i_sym, i_sym_valid       : soft symbol input (only the sign bit matters)
//   o_sym_ready              : symbol accepted when i_sym_valid & o_sym_ready
//   i_unlock                 : clears o_locked
//   o_corr, o_corr_valid     : correlation of the last evaluation + strobe
//   o_sync, o_locked         : detection pulse, detection level
// Handshake: a symbol transfers on a rising edge where i_sym_valid and
// o_sym_ready are both high; upstream holds the symbol while ready is low.
module manchester_sync_ctrl
    import manchester_sync_pkg::*;
#(
    parameter int                 TAP_NUM  = 16,
    parameter logic [TAP_NUM-1:0] PREAMBLE = 16'hA5F0,
    parameter int                 CORR_W   = 6,
    parameter int                 THRESH   = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [1:0]               i_sym,
    input  logic                     i_sym_valid,
    output logic                     o_sym_ready,
    input  logic                     i_unlock,
    output logic signed [CORR_W-1:0] o_corr,
    output logic                     o_corr_valid,
    output logic                     o_sync,
    output logic                     o_locked
);

    localparam int IDX_W  = (TAP_NUM > 1) ? $clog2(TAP_NUM) : 1;
    localparam int FILL_W = $clog2(TAP_NUM + 1);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(TAP_NUM - 1);
    localparam logic [FILL_W-1:0]        FILL_FULL = FILL_W'(TAP_NUM);
    localparam logic signed [CORR_W-1:0] THRESH_C  = CORR_W'(THRESH);

    state_e                     state_q, state_d;
    logic [1:0]                 hist_q [TAP_NUM];
    logic [1:0]                 hist_d [TAP_NUM];
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [CORR_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic signed [CORR_W-1:0]   corr_q, corr_d;
    logic                       corr_valid_q, corr_valid_d;
    logic                       sync_q, sync_d;
    logic                       locked_q, locked_d;
    logic                       sym_ready;

    logic [1:0]                 tap_sym;
    logic [1:0]                 pre_sym;
    logic [1:0]                 prod;

    // Only the sign bits carry information downstream.
    logic                       unused_bits;
    assign unused_bits = i_sym[0] ^ prod[0];

    assign tap_sym = hist_q[idx_q];
    assign pre_sym = pre_bit_to_sym(PREAMBLE[idx_q]);

    product #(
        .A_W(2),
        .B_W(2),
        .P_W(2)
    ) u_product (
        .i_a(tap_sym),
        .i_b(pre_sym),
        .o_p(prod)
    );

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        corr_d       = corr_q;
        corr_valid_d = 1'b0;
        sync_d       = 1'b0;
        locked_d     = i_unlock ? 1'b0 : locked_q;
        sym_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                sym_ready = i_enable;
                if (i_sym_valid && i_enable) begin
                    // Store a clean +/-1 code derived from the sign bit.
                    hist_d[0] = i_sym[1] ? SYM_NEG : SYM_POS;
                    for (int k = 1; k < TAP_NUM; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = prod[1] ? (acc_q - CORR_W'(1)) : (acc_q + CORR_W'(1));
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                corr_d       = acc_q;
                corr_valid_d = 1'b1;
                // A detection here overrides a simultaneous unlock.
                if (fill_q == FILL_FULL && acc_q >= THRESH_C && !locked_q) begin
                    sync_d   = 1'b1;
                    locked_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            for (int k = 0; k < TAP_NUM; k++) begin
                hist_q[k] <= SYM_POS;
            end
            idx_q        <= '0;
            acc_q        <= '0;
            fill_q       <= '0;
            corr_q       <= '0;
            corr_valid_q <= 1'b0;
            sync_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            corr_q       <= corr_d;
            corr_valid_q <= corr_valid_d;
            sync_q       <= sync_d;
            locked_q     <= locked_d;
        end
    end

    // Ready is held low while reset is applied, whatever the state.
    assign o_sym_ready  = sym_ready & ~i_rst;
    assign o_corr       = corr_q;
    assign o_corr_valid = corr_valid_q;
    assign o_sync       = sync_q;
    assign o_locked     = locked_q;

endmodule
